spi_transaction_fsm: RTL

Control state machine that sequences one SPI memory transaction around the serial/parallel shift register, the address latch and the data memory. It counts synchronized SCLK edges from the input conditioners, decodes the read/write bit after the address byte, and drives the shift register's parallel load, the address-latch and memory write enables, and the MISO tri-state enable. It sits between the input conditioners (CS, SCLK edge pulses) and the shift register / data memory datapath.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_bit_counter.sv | 51 +++++
 rtl/spi_transaction_fsm.sv | 139 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transaction controller
//
// Purpose: state encoding, read/write bit polarity and default frame width
// shared by spi_transaction_fsm and spi_bit_counter.
// Ports: none (package).

package spi_pkg;

  // Bits per frame phase (address+R/W byte, data byte).
  localparam int SPI_WIDTH_DEFAULT = 8;

  // Value of the R/W bit (shift register bit 0 after the address byte) for a read.
  localparam logic SPI_RW_READ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_GET_ADDR    = 3'd1,
    ST_DECODE      = 3'd2,
    ST_READ_LOAD   = 3'd3,
    ST_READ_SHIFT  = 3'd4,
    ST_WRITE_GET   = 3'd5,
    ST_WRITE_STORE = 3'd6,
    ST_DONE        = 3'd7
  } spi_state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// rtl/spi_bit_counter.sv - SCLK edge counter for one frame phase
//
// Purpose: counts qualified SCLK edges within a state; cleared whenever the
// controller enters a new state.
// Ports:
//   clk_i   in   FPGA clock, rising edge
//   reset_i in   synchronous active-high reset
//   clr_i   in   clear count to 0 (state entry)
//   en_i    in   count one edge this cycle
//   done_o  out  this enabled edge brings the count to width

module spi_bit_counter
  import spi_pkg::*;
#(
  parameter int width = SPI_WIDTH_DEFAULT,
  parameter int CNTW  = $clog2(width + 1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // done looks at the count the edge is about to produce, so the FSM can leave
  // the counting state on the same clock that registers the width-th edge.
  // It deliberately ignores clr_i: clr_i is derived from the FSM's next state,
  // which itself depends on done_o.
  assign done_o = en_i && (cnt_q == CNTW'(width - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_transaction_fsm.sv
// rtl/spi_transaction_fsm.sv - control FSM sequencing one SPI memory transaction
//
// Purpose: counts conditioned SCLK edges, decodes the R/W bit after the address
// byte, and drives the shift register parallel load, address latch and data
// memory write enables and the MISO buffer enable. All outputs are Moore
// decodes of the registered state.
// Optional feature macro: SPI_FSM_FRAME_ERR_EN adds frameErr, a one-cycle
// pulse when csN rises while a frame is in progress (not IDLE/DONE).
// Ports:
//   clk       in   FPGA clock, rising edge
//   reset     in   synchronous active-high reset
//   csN       in   conditioned chip select, active low
//   sclkRise  in   one-cycle pulse, SCLK rising edge
//   sclkFall  in   one-cycle pulse, SCLK falling edge
//   rwBit     in   shift register bit 0 after address byte (1 = read)
//   srLoad    out  shift register parallel load
//   addrWE    out  address latch write enable
//   dmWE      out  data memory write enable
//   misoBufe  out  MISO output buffer enable
//   frameErr  out  aborted-frame pulse (only with SPI_FSM_FRAME_ERR_EN)

module spi_transaction_fsm
  import spi_pkg::*;
#(
  parameter int width = SPI_WIDTH_DEFAULT,
  parameter int CNTW  = $clog2(width + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic csN,
  input  logic sclkRise,
  input  logic sclkFall,
  input  logic rwBit,
  output logic srLoad,
  output logic addrWE,
  output logic dmWE,
  output logic misoBufe
`ifdef SPI_FSM_FRAME_ERR_EN
  ,
  output logic frameErr
`endif
);

  spi_state_e state_q;
  spi_state_e state_d;
  logic       cnt_en;
  logic       cnt_clr;
  logic       cnt_done;

  // Every state change restarts the bit count from zero.
  assign cnt_clr = (state_d != state_q);

  spi_bit_counter #(
    .width(width),
    .CNTW (CNTW)
  ) u_bit_counter (
    .clk_i  (clk),
    .reset_i(reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .done_o (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    cnt_en   = 1'b0;
    srLoad   = 1'b0;
    addrWE   = 1'b0;
    dmWE     = 1'b0;
    misoBufe = 1'b0;

    // Only the edge relevant to the state is counted; a simultaneous opposite
    // edge is dropped. Chip-select release suppresses counting entirely.
    unique case (state_q)
      ST_GET_ADDR,
      ST_WRITE_GET:  cnt_en = sclkRise && !csN;
      ST_READ_SHIFT: cnt_en = sclkFall && !csN;
      default:       cnt_en = 1'b0;
    endcase

    unique case (state_q)
      ST_DECODE:     addrWE   = 1'b1;
      ST_READ_LOAD: begin
        srLoad   = 1'b1;
        misoBufe = 1'b1;
      end
      ST_READ_SHIFT: misoBufe = 1'b1;
      ST_WRITE_STORE: dmWE    = 1'b1;
      default: ;
    endcase

    if (csN) begin
      // Deselect aborts from anywhere; a partial write never reaches WRITE_STORE.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:        state_d = ST_GET_ADDR;
        ST_GET_ADDR:    if (cnt_done) state_d = ST_DECODE;
        ST_DECODE:      state_d = (rwBit == SPI_RW_READ) ? ST_READ_LOAD : ST_WRITE_GET;
        ST_READ_LOAD:   state_d = ST_READ_SHIFT;
        ST_READ_SHIFT:  if (cnt_done) state_d = ST_DONE;
        ST_WRITE_GET:   if (cnt_done) state_d = ST_WRITE_STORE;
        ST_WRITE_STORE: state_d = ST_DONE;
        ST_DONE:        state_d = ST_DONE;
        default:        state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef SPI_FSM_FRAME_ERR_EN
  logic frame_err_q;
  logic frame_err_d;

  // Registered so it lines up with the cycle the FSM shows IDLE after the abort;
  // the state is IDLE from then on, so the pulse cannot stretch.
  always_comb begin
    frame_err_d = csN && (state_q != ST_IDLE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frameErr = frame_err_q;
`endif

endmodule
